// File: rtl/spsram_128x50_arb_pkg.sv
// Shared FSM state type and sizing constants for the two-port SRAM arbiter.
package spsram_128x50_arb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_e;

   localparam int SPSRAM_DEPTH = 128;

   // All-ones lane mask, sliced down to the instance's lane count where used.
   localparam logic [63:0] SPSRAM_WEN_IDLE = '1;

endpackage

// File: rtl/spsram_128x50_arb_if.sv
// Request/response and SRAM-macro signal bundle; slave = arbiter side, master = requesters + SRAM side.
interface spsram_128x50_arb_if #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 50,
   parameter int WE_WIDTH   = 5
);

   logic                  req0_vld;
   logic                  req0_wr;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_wdata;
   logic [WE_WIDTH-1:0]   req0_wen;
   logic                  req0_rdy;

   logic                  req1_vld;
   logic                  req1_wr;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_wdata;
   logic [WE_WIDTH-1:0]   req1_wen;
   logic                  req1_rdy;

   logic                  rsp0_vld;
   logic                  rsp1_vld;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  init_busy;

   logic                  mem_cen;
   logic [WE_WIDTH-1:0]   mem_wen;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic [DATA_WIDTH-1:0] mem_d;
   logic [DATA_WIDTH-1:0] mem_q;

   modport slave (
      input  req0_vld, req0_wr, req0_addr, req0_wdata, req0_wen,
      input  req1_vld, req1_wr, req1_addr, req1_wdata, req1_wen,
      input  mem_q,
      output req0_rdy, req1_rdy,
      output rsp0_vld, rsp1_vld, rsp_data, init_busy,
      output mem_cen, mem_wen, mem_a, mem_d
   );

   modport master (
      output req0_vld, req0_wr, req0_addr, req0_wdata, req0_wen,
      output req1_vld, req1_wr, req1_addr, req1_wdata, req1_wen,
      output mem_q,
      input  req0_rdy, req1_rdy,
      input  rsp0_vld, rsp1_vld, rsp_data, init_busy,
      input  mem_cen, mem_wen, mem_a, mem_d
   );

endinterface

// File: rtl/spsram_rr_arb2.sv
// Two-way round-robin grant, combinational from req_i; the pointer flips to the other side after every grant.
module spsram_rr_arb2
   import spsram_128x50_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_i[0] && (!req_i[1] || (ptr_q == 1'b0))) begin
            gnt_o = 2'b01;
         end else if (req_i[1]) begin
            gnt_o = 2'b10;
         end
      end

      ptr_d = ptr_q;
      if (gnt_o[0]) begin
         ptr_d = 1'b1;
      end else if (gnt_o[1]) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/spsram_128x50_arb.sv
// Two-requester arbiter in front of a 128x50 single-port SRAM: one grant per cycle, read data one cycle later, no response backpressure.
// SPSRAM_ARB_INIT_EN adds a post-reset clear of all 128 words before requests are accepted.
module spsram_128x50_arb
   import spsram_128x50_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 50,
   parameter int WE_WIDTH   = 5
) (
   input  logic               CLK,
   input  logic               RST,
   spsram_128x50_arb_if.slave bus
);

   localparam logic [WE_WIDTH-1:0] WEN_IDLE = SPSRAM_WEN_IDLE[WE_WIDTH-1:0];

   arb_state_e            state_q;
   logic                  run;
   logic [1:0]            gnt;
   logic                  init_act;
   logic [ADDR_WIDTH-1:0] init_addr;

   logic                  rsp0_vld_q, rsp0_vld_d;
   logic                  rsp1_vld_q, rsp1_vld_d;
   logic                  rsp0_vld, rsp1_vld;

   logic                  mem_cen;
   logic [WE_WIDTH-1:0]   mem_wen;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic [DATA_WIDTH-1:0] mem_d;

`ifdef SPSRAM_ARB_INIT_EN
   logic [ADDR_WIDTH-1:0] init_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else if (state_q == ST_INIT) begin
         init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
         if (init_cnt_q == ADDR_WIDTH'(SPSRAM_DEPTH - 1)) begin
            state_q <= ST_RUN;
         end
      end
   end

   assign init_act      = (state_q == ST_INIT);
   assign init_addr     = init_cnt_q;
   assign bus.init_busy = init_act && !RST;
`else
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_RUN;
      end
   end

   assign init_act      = 1'b0;
   assign init_addr     = '0;
   assign bus.init_busy = 1'b0;
`endif

   // Reset overrides everything combinationally so requesters never see a stale ready.
   assign run = (state_q == ST_RUN) && !RST;

   spsram_rr_arb2 u_rr_arb2 (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (run),
      .req_i ({bus.req1_vld, bus.req0_vld}),
      .gnt_o (gnt)
   );

   assign bus.req0_rdy = gnt[0];
   assign bus.req1_rdy = gnt[1];

   always_comb begin
      mem_cen = 1'b1;
      mem_wen = WEN_IDLE;
      mem_a   = '0;
      mem_d   = '0;
      if (!RST) begin
         if (init_act) begin
            mem_cen = 1'b0;
            mem_wen = '0;
            mem_a   = init_addr;
         end else if (gnt[0]) begin
            mem_cen = 1'b0;
            mem_a   = bus.req0_addr;
            if (bus.req0_wr) begin
               mem_wen = bus.req0_wen;
               mem_d   = bus.req0_wdata;
            end
         end else if (gnt[1]) begin
            mem_cen = 1'b0;
            mem_a   = bus.req1_addr;
            if (bus.req1_wr) begin
               mem_wen = bus.req1_wen;
               mem_d   = bus.req1_wdata;
            end
         end
      end
   end

   assign bus.mem_cen = mem_cen;
   assign bus.mem_wen = mem_wen;
   assign bus.mem_a   = mem_a;
   assign bus.mem_d   = mem_d;

   assign rsp0_vld_d = gnt[0] && !bus.req0_wr;
   assign rsp1_vld_d = gnt[1] && !bus.req1_wr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rsp0_vld_q <= 1'b0;
         rsp1_vld_q <= 1'b0;
      end else begin
         rsp0_vld_q <= rsp0_vld_d;
         rsp1_vld_q <= rsp1_vld_d;
      end
   end

   // A reset landing in the response cycle kills the pending response.
   assign rsp0_vld = rsp0_vld_q && !RST;
   assign rsp1_vld = rsp1_vld_q && !RST;

   assign bus.rsp0_vld = rsp0_vld;
   assign bus.rsp1_vld = rsp1_vld;
   assign bus.rsp_data = (rsp0_vld || rsp1_vld) ? bus.mem_q : '0;

endmodule

// File: doc/spsram_128x50_arb.md
SPSRAM_128X50_ARB -- requirements
Module: spsram_128x50_arb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 7, meaning the SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 50, meaning the SRAM word width.
REQ-003 The block SHALL have parameter WE_WIDTH, default 5, meaning the number of active-low write lanes, each DATA_WIDTH/WE_WIDTH bits wide.
REQ-004 The block SHALL have one clock and a synchronous active-high reset; ports CLK and RST.
REQ-005 The block SHALL have these ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active high
- req0_vld  in  1  requester 0 access request
- req0_wr  in  1  1=write, 0=read
- req0_addr  in  ADDR_WIDTH  word address
- req0_wdata  in  DATA_WIDTH  write data
- req0_wen  in  WE_WIDTH  active-low lane enables, writes only
- req0_rdy  out  1  request accepted this cycle
- req1_vld, req1_wr, req1_addr, req1_wdata, req1_wen, req1_rdy: same as requester 0, for requester 1
- rsp0_vld  out  1  read data for requester 0 is valid
- rsp1_vld  out  1  read data for requester 1 is valid
- rsp_data  out  DATA_WIDTH  read data
- init_busy  out  1  clear sequence in progress
- mem_cen  out  1  SRAM chip enable, active low
- mem_wen  out  WE_WIDTH  SRAM lane write enables, active low
- mem_a  out  ADDR_WIDTH  SRAM address
- mem_d  out  DATA_WIDTH  SRAM write data
- mem_q  in  DATA_WIDTH  SRAM read data, one cycle after the access

Function
REQ-006 The FSM SHALL have two states, INIT and RUN, and SHALL transition INIT->RUN only on the cycle after the address-127 write.
REQ-007 In RUN, the arbiter SHALL grant at most one request per cycle; a request is accepted when reqN_vld=1 and reqN_rdy=1 in the same cycle.
REQ-008 reqN_rdy SHALL be combinational: reqN_vld & grantN & (state==RUN).
REQ-009 Arbitration SHALL be round-robin via a 1-bit priority pointer:
- single requester: it is granted
- both requesting: the pointer's requester is granted
- after any grant, the pointer moves to the other requester
REQ-010 On a granted access the block SHALL drive in the same cycle: mem_cen=0, mem_a=addr.
- write: mem_wen=reqN_wen, mem_d=reqN_wdata
- read: mem_wen=all ones, mem_d=0
REQ-011 When there is no grant in RUN, the block SHALL drive mem_cen=1, mem_wen=all ones, mem_a=0, mem_d=0.
REQ-012 Read latency SHALL be 1 cycle: rspN_vld SHALL be asserted in the cycle after the read grant, for exactly one cycle, with rsp_data=mem_q combinationally.
REQ-013 rsp_data SHALL be 0 when neither rsp0_vld nor rsp1_vld is asserted.
REQ-014 Writes SHALL produce no response.
REQ-015 A write with reqN_wen all ones SHALL still be granted and issued (no-op at the SRAM).
REQ-016 Back-to-back grants SHALL be sustained at one per cycle; there is no backpressure on responses.
REQ-017 In INIT the block SHALL write 0 to addresses 0..127 in ascending order, one per cycle, with mem_cen=0, mem_wen=0, mem_d=0, init_busy=1, and both rdy=0.

Reset
REQ-018 On RST=1 at a CLK edge the block SHALL set: pointer=requester 0, rsp0_vld=0, rsp1_vld=0, init counter=0, and state=INIT (RUN without the macro).
REQ-019 A reset during INIT SHALL restart the clear at address 0.
REQ-020 A reset asserted in the cycle after a read grant SHALL suppress that read's rspN_vld.
REQ-021 While RST=1, the block SHALL drive mem_cen=1, both rdy=0, and init_busy=0.

Configuration
REQ-022 With macro SPSRAM_ARB_INIT_EN defined, the INIT state, the 7-bit init counter and the clear sequence SHALL be present, and init_busy SHALL behave per REQ-017.
REQ-023 Without SPSRAM_ARB_INIT_EN, reset SHALL go directly to RUN and init_busy SHALL be tied to 0.

Structure
REQ-024 A shared package SHALL hold the FSM state typedef (INIT, RUN) and the constants SPSRAM_DEPTH=128 and SPSRAM_WEN_IDLE (all ones).
REQ-025 The block SHALL contain one natural sub-module, spsram_rr_arb2: the 2-way round-robin grant plus pointer register.
REQ-026 The SRAM macro wrapper SHALL be instantiated outside this block and connected through the mem_* ports.

Verification
REQ-027 Release RST with the macro defined -> init_busy=1 for 128 cycles, mem_a=0..127, mem_wen=5'b00000, mem_d=0; then state RUN and init_busy=0.
REQ-028 Requester 0 writes addr 7 with data 50'h3_FFFF_0000_1234 and wen 5'b00000, then reads addr 7 -> rsp0_vld=1 one cycle after the read grant, rsp_data=50'h3_FFFF_0000_1234.
REQ-029 Both requesters assert continuous reads after reset -> grants alternate 0,1,0,1; rsp0_vld and rsp1_vld alternate with 1-cycle latency; the SRAM is accessed every cycle.
REQ-030 Write to addr 3 with wen 5'b11110 and data all ones over prior contents 0, then read addr 3 -> rsp_data=50'h0_0000_0000_03FF (lane 0 only).
REQ-031 Assert RST at init address 60 -> after release, the clear restarts at address 0 and runs 128 cycles; a read during INIT gets rdy=0 until RUN.
REQ-032 Build without SPSRAM_ARB_INIT_EN, read issued on the first cycle after reset -> req0_rdy=1 immediately, init_busy stays 0.
